// File: rtl/exec_pkg.sv
// Shared definitions for the operator-panel execution unit: widths, opcodes, FSM states.
package exec_pkg;

  localparam int DW = 4;
  localparam int IW = 4;
  localparam int NREGS = 1 << IW;

  typedef logic [DW-1:0] data_t;
  typedef logic [IW-1:0] idx_t;

  localparam logic [3:0] OP_ADD     = 4'h0;
  localparam logic [3:0] OP_SUB     = 4'h1;
  localparam logic [3:0] OP_AND     = 4'h2;
  localparam logic [3:0] OP_OR      = 4'h3;
  localparam logic [3:0] OP_XOR     = 4'h4;
  localparam logic [3:0] OP_NOT     = 4'h5;
  localparam logic [3:0] OP_SHL     = 4'h6;
  localparam logic [3:0] OP_SHR     = 4'h7;
  localparam logic [3:0] OP_LDI     = 4'h8;
  localparam logic [3:0] OP_MOV     = 4'h9;
  localparam logic [3:0] OP_INC     = 4'hA;
  localparam logic [3:0] OP_DEC     = 4'hB;
  localparam logic [3:0] OP_NOP_MIN = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  function automatic logic is_nop(input logic [3:0] op);
    return op >= OP_NOP_MIN;
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU: 5-bit unsigned arithmetic with carry/borrow flags.
// Saturation on flow errors is selected by EXEC_SAT_EN.
module exec_alu
  import exec_pkg::*;
(
  input  logic [3:0] op,
  input  data_t      a,
  input  data_t      b,
  input  data_t      imm,
  output data_t      result,
  output logic       overflow,
  output logic       underflow
);

  logic [DW:0] wide;
  logic        ov_raw;
  logic        un_raw;

  always_comb begin
    wide   = '0;
    ov_raw = 1'b0;
    un_raw = 1'b0;
    case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        ov_raw = wide[DW];
      end
      OP_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        un_raw = a < b;
      end
      OP_AND: wide = {1'b0, a & b};
      OP_OR:  wide = {1'b0, a | b};
      OP_XOR: wide = {1'b0, a ^ b};
      OP_NOT: wide = {1'b0, ~a};
      OP_SHL: begin
        wide   = {a, 1'b0};
        ov_raw = wide[DW];
      end
      OP_SHR: wide = {2'b00, a[DW-1:1]};
      OP_LDI: wide = {1'b0, imm};
      OP_MOV: wide = {1'b0, a};
      OP_INC: begin
        wide   = {1'b0, a} + 5'd1;
        ov_raw = wide[DW];
      end
      OP_DEC: begin
        wide   = {1'b0, a} - 5'd1;
        un_raw = (a == '0);
      end
      default: wide = '0;
    endcase
  end

  always_comb begin
    overflow  = ov_raw;
    underflow = un_raw;
`ifdef EXEC_SAT_EN
    if (ov_raw)
      result = '1;
    else if (un_raw)
      result = '0;
    else
      result = wide[DW-1:0];
`else
    result = wide[DW-1:0];
`endif
  end

endmodule

// File: rtl/exec_unit.sv
// Execution unit: 16x4 register file plus IDLE/READ/EXEC/WRITE sequencer.
// EXEC_SAT_EN selects saturating write-back on flow errors.
//
//   state    | meaning
//   ST_IDLE  | waiting for start; fields latched on start
//   ST_READ  | operands A/B read from the register file
//   ST_EXEC  | ALU result and flags registered
//   ST_WRITE | write-back, done pulse
module exec_unit
  import exec_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] op,
  input  logic [3:0] rd1,
  input  logic [3:0] rd2,
  input  logic [3:0] wr,
  output logic       busy,
  output logic       done,
  output logic [3:0] alu_result,
  output logic       overflow,
  output logic       underflow,
  output logic       flowcheck
);

  state_t     state;
  data_t      regs [NREGS];
  logic [3:0] op_q;
  idx_t       rd1_q;
  idx_t       rd2_q;
  idx_t       wr_q;
  data_t      a_q;
  data_t      b_q;
  logic       wen_q;

  data_t      alu_res;
  logic       alu_ov;
  logic       alu_un;
  logic       wen_next;

  exec_alu u_alu (
    .op        (op_q),
    .a         (a_q),
    .b         (b_q),
    .imm       (rd1_q),
    .result    (alu_res),
    .overflow  (alu_ov),
    .underflow (alu_un)
  );

  // Saturating builds still commit on a flow error; otherwise the error suppresses the write.
  always_comb begin
`ifdef EXEC_SAT_EN
    wen_next = !is_nop(op_q);
`else
    wen_next = !is_nop(op_q) && !(alu_ov || alu_un);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_q       <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      wr_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      wen_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      alu_result <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      flowcheck  <= 1'b0;
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= op;
            rd1_q <= rd1;
            rd2_q <= rd2;
            wr_q  <= wr;
            busy  <= 1'b1;
            state <= ST_READ;
          end
        end
        ST_READ: begin
          a_q   <= regs[rd1_q];
          b_q   <= regs[rd2_q];
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          alu_result <= alu_res;
          overflow   <= alu_ov;
          underflow  <= alu_un;
          flowcheck  <= alu_ov | alu_un;
          wen_q      <= wen_next;
          done       <= 1'b1;
          state      <= ST_WRITE;
        end
        ST_WRITE: begin
          if (wen_q)
            regs[wr_q] <= alu_result;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed table, multi-cycle corner cases,
// and randomized instructions against an arithmetic reference model.
module tb_exec_unit;

`ifdef EXEC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] op = '0;
  logic [3:0] rd1 = '0;
  logic [3:0] rd2 = '0;
  logic [3:0] wr = '0;
  logic       busy;
  logic       done;
  logic [3:0] alu_result;
  logic       overflow;
  logic       underflow;
  logic       flowcheck;

  exec_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .rd1        (rd1),
    .rd2        (rd2),
    .wr         (wr),
    .busy       (busy),
    .done       (done),
    .alu_result (alu_result),
    .overflow   (overflow),
    .underflow  (underflow),
    .flowcheck  (flowcheck)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int mregs [16];

  typedef struct {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] w;
    int         res;
    int         ov;
    int         un;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add_vec(input int o, input int a, input int b, input int w,
                                  input int res, input int ov, input int un);
    vec_t v;
    v.op = 4'(o); v.a = 4'(a); v.b = 4'(b); v.w = 4'(w);
    v.res = res; v.ov = ov; v.un = un;
    tbl.push_back(v);
  endfunction

  // Reference: plain integer arithmetic, range test decides the flags.
  function automatic void model(input int o, input int ia, input int ib, input int w,
                                output int res, output int ov, output int un);
    int av, bv, full;
    bit nop;
    av = mregs[ia];
    bv = mregs[ib];
    nop = 1'b0;
    case (o)
      0:  full = av + bv;
      1:  full = av - bv;
      2:  full = av & bv;
      3:  full = av | bv;
      4:  full = av ^ bv;
      5:  full = 15 - av;
      6:  full = av * 2;
      7:  full = av / 2;
      8:  full = ia;
      9:  full = av;
      10: full = av + 1;
      11: full = av - 1;
      default: begin full = 0; nop = 1'b1; end
    endcase
    ov  = (full > 15) ? 1 : 0;
    un  = (full < 0) ? 1 : 0;
    res = full & 15;
    if (SAT && ov == 1) res = 15;
    if (SAT && un == 1) res = 0;
    if (!nop && (SAT || (ov == 0 && un == 0)))
      mregs[w] = res;
  endfunction

  task automatic run_instr(input int o, input int a, input int b, input int w, input string tag,
                           output int res, output int ov, output int un);
    int cyc;
    @(negedge clk);
    op = 4'(o); rd1 = 4'(a); rd2 = 4'(b); wr = 4'(w);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_c1"}, busy, 1);
    cyc = 1;
    while (!done && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " done_cycle"}, cyc, 3);
    res = alu_result;
    ov  = overflow;
    un  = underflow;
    chk({tag, " flowcheck"}, flowcheck, (overflow | underflow));
    @(negedge clk);
    chk({tag, " busy_after"}, busy, 0);
    chk({tag, " done_after"}, done, 0);
  endtask

  task automatic run_model(input int o, input int a, input int b, input int w, input string tag);
    int er, eo, eu, r, ov, un;
    model(o, a, b, w, er, eo, eu);
    run_instr(o, a, b, w, tag, r, ov, un);
    chk({tag, " result"}, r, er);
    chk({tag, " overflow"}, ov, eo);
    chk({tag, " underflow"}, un, eu);
  endtask

  initial begin
    int r, ov, un, er, eo, eu, dones, cap;
    for (int i = 0; i < 16; i++) mregs[i] = 0;

    // Directed table: {op, rd1, rd2, wr, result, ov, un}
    add_vec(8, 5, 0, 1, 5, 0, 0);
    add_vec(8, 3, 0, 2, 3, 0, 0);
    add_vec(0, 1, 2, 3, 8, 0, 0);
    add_vec(9, 3, 0, 3, 8, 0, 0);
    add_vec(8, 9, 0, 1, 9, 0, 0);
    add_vec(8, 8, 0, 2, 8, 0, 0);
    add_vec(0, 1, 2, 4, SAT ? 15 : 1, 1, 0);
    add_vec(9, 4, 0, 4, SAT ? 15 : 0, 0, 0);
    add_vec(8, 2, 0, 1, 2, 0, 0);
    add_vec(8, 7, 0, 2, 7, 0, 0);
    add_vec(1, 1, 2, 5, SAT ? 0 : 11, 0, 1);
    add_vec(9, 5, 0, 5, 0, 0, 0);
    add_vec(14, 1, 2, 1, 0, 0, 0);
    add_vec(9, 1, 0, 1, 2, 0, 0);
    add_vec(8, 15, 0, 7, 15, 0, 0);
    add_vec(10, 7, 0, 8, SAT ? 15 : 0, 1, 0);
    add_vec(11, 0, 0, 9, SAT ? 0 : 15, 0, 1);
    add_vec(6, 7, 0, 12, SAT ? 15 : 14, 1, 0);
    add_vec(7, 7, 0, 13, 7, 0, 0);
    add_vec(1, 7, 7, 7, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset alu_result", alu_result, 0);
    chk("reset overflow", overflow, 0);
    chk("reset underflow", underflow, 0);
    chk("reset flowcheck", flowcheck, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      model(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].w, er, eo, eu);
      run_instr(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].w, tag, r, ov, un);
      chk({tag, " result"}, r, tbl[i].res);
      chk({tag, " overflow"}, ov, tbl[i].ov);
      chk({tag, " underflow"}, un, tbl[i].un);
    end

    // Second start while busy must be ignored.
    @(negedge clk);
    op = 4'h8; rd1 = 4'd7; rd2 = 4'd0; wr = 4'd10;
    start = 1'b1;
    @(negedge clk);
    op = 4'h8; rd1 = 4'd1; rd2 = 4'd0; wr = 4'd11;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    cap = -1;
    for (int c = 0; c < 10; c++) begin
      if (done) begin
        dones++;
        cap = alu_result;
      end
      @(negedge clk);
    end
    chk("ignore done_count", dones, 1);
    chk("ignore result", cap, 7);
    mregs[10] = 7;
    run_model(9, 10, 0, 10, "ignore r10");
    run_model(9, 11, 0, 11, "ignore r11");

    // Reset asserted during EXEC aborts the instruction.
    @(negedge clk);
    op = 4'h8; rd1 = 4'd7; rd2 = 4'd0; wr = 4'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort alu_result", alu_result, 0);
    chk("abort overflow", overflow, 0);
    chk("abort underflow", underflow, 0);
    chk("abort flowcheck", flowcheck, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) mregs[i] = 0;
    run_model(9, 6, 0, 6, "abort r6");
    run_model(8, 7, 0, 6, "post-abort ldi");
    run_model(9, 1, 0, 1, "post-abort r1");

    // Randomized instructions against the model.
    for (int i = 0; i < 200; i++) begin
      run_model($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 15), $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
# exec_unit

Instruction execution unit on the processor side of the operator-panel interface. Accepts the four 4-bit instruction fields (opcode, two source register indexes, destination register index) latched by the panel front-end on a one-cycle start pulse. Reads a 16 x 4-bit register file, executes one ALU operation, writes back, and returns the 4-bit result with overflow/underflow flags for display.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; instruction fields valid this cycle
- op  in  4  opcode
- rd1  in  4  source register index A; immediate value for LDI
- rd2  in  4  source register index B
- wr  in  4  destination register index
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when write-back completes
- alu_result  out  4  result of the last completed instruction
- overflow  out  1  last instruction carried out of bit 3
- underflow  out  1  last instruction borrowed below zero
- flowcheck  out  1  overflow | underflow

## Operation
- Opcodes: 0 ADD A+B, 1 SUB A-B, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A<<1, 7 SHR A>>1, 8 LDI (result = rd1 field), 9 MOV A, A INC A+1, B DEC A-1, C–F NOP (no write, flags cleared, alu_result = 0).
- Arithmetic is unsigned, 5-bit internally. ADD/INC/SHL: overflow = bit 4 of the 5-bit sum or shift. SUB/DEC: underflow = A < subtrahend. All other ops clear both flags.
- Flags are mutually exclusive. flowcheck is their OR.
- Write-back goes to reg[wr] without EXEC_SAT_EN unless flowcheck is set. On a flow error the register file is unchanged and alu_result = truncated low 4 bits.
- Reading and writing the same index: the source operand is the pre-instruction value.
- FSM states: IDLE, READ (latch fields, read A = reg[rd1], B = reg[rd2]), EXEC (compute, register result/flags), WRITE (write-back, done = 1), then back to IDLE.
- start is honoured only in IDLE. start while busy is ignored, and the fields are not re-latched.
- Reset: all registers = 0, state = IDLE, busy = 0, done = 0, alu_result = 0, overflow = 0, underflow = 0, flowcheck = 0. Reset asserted mid-instruction aborts it with no write-back.

## Timing
- Cycle 0: start sampled high in IDLE. Cycle 1: READ, busy = 1. Cycle 2: EXEC. Cycle 3: WRITE, done = 1, register written at the end of the cycle.
- alu_result and the flags update at the end of EXEC. They are visible in cycle 3 and hold until the next instruction's EXEC.
- busy deasserts in the cycle after WRITE. A new start is accepted in that cycle, giving 4 cycles per instruction minimum.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- EXEC_SAT_EN defined: saturating arithmetic. On overflow, result = 4'hF; on underflow, result = 4'h0. The saturated value is written to reg[wr] and shown on alu_result. Flags are still asserted.
- EXEC_SAT_EN undefined: non-saturating behaviour as in Operation (no write-back on flow error, truncated alu_result).

## Structure
- Shared package exec_pkg holds the opcode constants (OP_ADD … OP_DEC, OP_NOP range), the FSM state encoding, and the 4-bit data/index widths.
- One sub-module, exec_alu: purely combinational. Inputs: op, A, B, imm. Outputs: 4-bit result, overflow, underflow. Saturation is selected inside it under EXEC_SAT_EN.
- The register file and FSM live in exec_unit.

## Test plan
- Reset, then LDI 5 -> r1 and LDI 3 -> r2, then ADD r1,r2 -> r3: done at cycle 3 after start, alu_result = 8, flags 0, r3 = 8.
- r1 = 9, r2 = 8, ADD -> r4: overflow = 1, flowcheck = 1. Without EXEC_SAT_EN: alu_result = 1, r4 unchanged. With EXEC_SAT_EN: alu_result = F, r4 = F.
- r1 = 2, r2 = 7, SUB -> r5: underflow = 1. Without EXEC_SAT_EN: alu_result = B, r5 unchanged. With EXEC_SAT_EN: alu_result = 0.
- Second start pulse during READ: ignored. Exactly one done pulse; result matches the first instruction's fields.
- rst_n driven low during EXEC of LDI 7 -> r6: r6 = 0, all outputs 0, state IDLE. The next start executes normally.
- Opcode E: no register changes, alu_result = 0, flags 0. done still pulses at cycle 3.
